dpll_trim_controller: RTL and testbench

Frequency-locking controller for the 13-stage, 26-trim-bit ring oscillator. It runs on the oscillator's own fast clock, `hiclock`, and counts `hiclock` cycles per period of an external reference `osc`. It sums two consecutive period counts, compares the sum against a programmed divider target, and steps a 0..26 trim value up or down. That value is driven onto the oscillator trim bus in primary-first order.

---
 rtl/dpll_trim_controller.sv | 169 ++++++++++++++++
 tb/tb_dpll_trim_controller.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/dpll_trim_controller.sv
// dpll_trim_controller: counts hiclock cycles per osc period and steps a 0..26 thermometer trim.
// Optional lock detector compiled in with `define DPLL_LOCK_DETECT_EN.
module dpll_trim_controller #(
  parameter int CNT_W      = 6,
  parameter int DEADBAND   = 1,
  parameter int LOCK_COUNT = 4
) (
  input  logic        hiclock,
  input  logic        ireset,
  input  logic        enable,
  input  logic        osc,
  input  logic [4:0]  div,
  output logic [25:0] trim,
  output logic [4:0]  tval,
  output logic        lock
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [4:0]       TVAL_MAX = 5'd26;

  typedef enum logic [1:0] {
    ST_DISABLED,
    ST_ARM,
    ST_FILL,
    ST_TRACK
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       sync_q, sync_d;
  logic             edge_p;
  logic [CNT_W-1:0] cur_q, cur_d;
  logic [CNT_W-1:0] prev_q, prev_d;
  logic [CNT_W-1:0] last_q, last_d;
  logic             upd_q, upd_d;
  logic [4:0]       tval_q, tval_d;
  logic [25:0]      trim_q, trim_d;
  logic [CNT_W:0]   sum;
  logic [5:0]       target;
  logic             too_fast;
  logic             too_slow;

  // sync_q[0..1] synchronize osc, sync_q[2] is the history bit for edge detection
  always_comb begin
    sync_d = {sync_q[1:0], osc};
  end

  assign edge_p = sync_q[1] & ~sync_q[2];

  // prev/last hold the two most recent complete periods once edge_p has been registered
  always_comb begin
    sum      = {1'b0, prev_q} + {1'b0, last_q};
    target   = {div, 1'b0};
    too_fast = int'(sum) > (int'(target) + DEADBAND);
    too_slow = int'(sum) < (int'(target) - DEADBAND);
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    prev_d  = prev_q;
    last_d  = last_q;
    upd_d   = 1'b0;
    tval_d  = tval_q;

    case (state_q)
      ST_DISABLED: if (enable) state_d = ST_ARM;
      ST_ARM:      if (edge_p) state_d = ST_FILL;
      ST_FILL:     if (edge_p) state_d = ST_TRACK;
      ST_TRACK:    upd_d = edge_p;
      default:     state_d = ST_DISABLED;
    endcase

    if (state_q != ST_DISABLED) begin
      if (edge_p) begin
        cur_d  = CNT_ONE;
        prev_d = cur_q;
        last_d = prev_q;
      end else if (cur_q != CNT_MAX) begin
        cur_d = cur_q + CNT_ONE;
      end
    end

    if (upd_q && (state_q == ST_TRACK)) begin
      if (too_fast && (tval_q != TVAL_MAX)) begin
        tval_d = tval_q + 5'd1;
      end else if (too_slow && (tval_q != 5'd0)) begin
        tval_d = tval_q - 5'd1;
      end
    end

    if (!enable) begin
      state_d = ST_DISABLED;
      cur_d   = '0;
      prev_d  = '0;
      last_d  = '0;
      upd_d   = 1'b0;
    end
  end

  // Trim is decoded from the next tval so both registers change on the same edge
  always_comb begin
    trim_d = '0;
    for (int k = 0; k < 26; k++) begin
      trim_d[k] = (k < int'(tval_d));
    end
  end

  always_ff @(posedge hiclock or posedge ireset) begin
    if (ireset) begin
      state_q <= ST_DISABLED;
      sync_q  <= '0;
      cur_q   <= '0;
      prev_q  <= '0;
      last_q  <= '0;
      upd_q   <= 1'b0;
      tval_q  <= '0;
      trim_q  <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cur_q   <= cur_d;
      prev_q  <= prev_d;
      last_q  <= last_d;
      upd_q   <= upd_d;
      tval_q  <= tval_d;
      trim_q  <= trim_d;
    end
  end

  assign tval = tval_q;
  assign trim = trim_q;

`ifdef DPLL_LOCK_DETECT_EN
  localparam int              LC_W   = $clog2(LOCK_COUNT + 1);
  localparam logic [LC_W-1:0] LC_MAX = LC_W'(LOCK_COUNT);

  logic [LC_W-1:0] band_cnt_q, band_cnt_d;
  logic            lock_q, lock_d;
  logic            oob_update;

  // An out-of-band update or leaving TRACK drops lock on the same edge that clears the count
  always_comb begin
    oob_update = upd_q && (too_fast || too_slow);
    band_cnt_d = band_cnt_q;
    if ((state_q != ST_TRACK) || !enable || oob_update) begin
      band_cnt_d = '0;
    end else if (upd_q && (band_cnt_q != LC_MAX)) begin
      band_cnt_d = band_cnt_q + 1'b1;
    end
    lock_d = (band_cnt_q == LC_MAX) && (state_q == ST_TRACK) && enable && !oob_update;
  end

  always_ff @(posedge hiclock or posedge ireset) begin
    if (ireset) begin
      band_cnt_q <= '0;
      lock_q     <= 1'b0;
    end else begin
      band_cnt_q <= band_cnt_d;
      lock_q     <= lock_d;
    end
  end

  assign lock = lock_q;
`else
  assign lock = 1'b0;
`endif

endmodule

// File: tb/tb_dpll_trim_controller.sv
// tb_dpll_trim_controller: directed checks of reset, hold, stepping, deadband and disable behaviour.
// osc periods are multiples of 10 ns so every hiclock count per period is exact.
`timescale 1ns/1ps
module tb_dpll_trim_controller;

  logic        hiclock = 1'b0;
  logic        ireset  = 1'b1;
  logic        enable  = 1'b0;
  logic        osc;
  logic [4:0]  div     = 5'd8;
  logic [25:0] trim;
  logic [4:0]  tval;
  logic        lock;

  int per_q[$];
  int osc_period = 80;
  int n_checks   = 0;
  int n_errors   = 0;

`ifdef DPLL_LOCK_DETECT_EN
  localparam logic LOCK_ON = 1'b1;
`else
  localparam logic LOCK_ON = 1'b0;
`endif

  dpll_trim_controller dut (
    .hiclock (hiclock),
    .ireset  (ireset),
    .enable  (enable),
    .osc     (osc),
    .div     (div),
    .trim    (trim),
    .tval    (tval),
    .lock    (lock)
  );

  always #5 hiclock = ~hiclock;

  // Queued periods are played once each; otherwise osc runs at the in-band default
  initial begin : osc_gen
    int p;
    osc = 1'b0;
    forever begin
      p = (per_q.size() > 0) ? per_q.pop_front() : osc_period;
      osc = 1'b1;
      #(p / 2);
      osc = 1'b0;
      #(p - p / 2);
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Queue n periods of p ns, wait until the last one starts, then let the trailing updates settle
  task automatic apply_stimulus(input int n, input int p);
    int spins;
    for (int i = 0; i < n; i++) per_q.push_back(p);
    spins = 0;
    while ((per_q.size() != 0) && (spins < 2000)) begin
      @(negedge hiclock);
      spins++;
    end
    if (per_q.size() != 0) begin
      n_errors++;
      $display("[TB] FAIL drain: %0d periods still queued, required 0", per_q.size());
    end
    #(p + 180);
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin : main
    #200;
    check_output("reset_trim", 32'(trim), 32'h0);
    check_output("reset_tval", 32'(tval), 32'd0);
    check_output("reset_lock", 32'(lock), 32'd0);

    ireset = 1'b0;
    #300;
    check_output("idle_tval", 32'(tval), 32'd0);
    check_output("idle_trim", 32'(trim), 32'h0);

    enable = 1'b1;
    #1280;
    check_output("hold_tval", 32'(tval), 32'd0);
    check_output("hold_trim", 32'(trim), 32'h0);
    check_output("hold_lock", 32'(lock), 32'(LOCK_ON));

    // sum 32 against target 16: six ups, then seven, then saturation
    apply_stimulus(5, 160);
    check_output("up6_tval", 32'(tval), 32'd6);
    check_output("up6_trim", 32'(trim), 32'h000003F);
    check_output("up6_lock", 32'(lock), 32'd0);
    apply_stimulus(6, 160);
    check_output("up13_tval", 32'(tval), 32'd13);
    check_output("up13_trim", 32'(trim), 32'h0001FFF);
    apply_stimulus(20, 160);
    check_output("sat26_tval", 32'(tval), 32'd26);
    check_output("sat26_trim", 32'(trim), 32'h3FFFFFF);
    #600;
    check_output("sat26_lock", 32'(lock), 32'(LOCK_ON));

    enable = 1'b0;
    #20;
    apply_stimulus(5, 40);
    check_output("dis_tval", 32'(tval), 32'd26);
    check_output("dis_lock", 32'(lock), 32'd0);
    enable = 1'b1;
    #800;
    check_output("reen_tval", 32'(tval), 32'd26);
    check_output("reen_lock", 32'(lock), 32'(LOCK_ON));

    apply_stimulus(20, 40);
    check_output("down5_tval", 32'(tval), 32'd5);
    check_output("down5_trim", 32'(trim), 32'h000001F);

    // sums of 15 and 17 are inside the deadband, 18 is one step out
    apply_stimulus(1, 70);
    check_output("band15_tval", 32'(tval), 32'd5);
    apply_stimulus(1, 90);
    check_output("band17_tval", 32'(tval), 32'd5);
    #600;
    check_output("band_lock", 32'(lock), 32'(LOCK_ON));
    apply_stimulus(2, 90);
    check_output("edge18_tval", 32'(tval), 32'd6);
    check_output("edge18_trim", 32'(trim), 32'h000003F);
    check_output("edge18_lock", 32'(lock), 32'd0);

    for (int k = 5; k >= 0; k--) begin
      apply_stimulus(2, 70);
      check_output("step_down_tval", 32'(tval), 32'(k));
    end
    apply_stimulus(2, 70);
    check_output("floor_tval", 32'(tval), 32'd0);
    check_output("floor_trim", 32'(trim), 32'h0);

    apply_stimulus(3, 160);
    check_output("preirst_tval", 32'(tval), 32'd4);
    ireset = 1'b1;
    #1;
    check_output("irst_tval", 32'(tval), 32'd0);
    check_output("irst_trim", 32'(trim), 32'h0);
    check_output("irst_lock", 32'(lock), 32'd0);
    #19;
    ireset = 1'b0;
    #200;
    check_output("postirst_tval", 32'(tval), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
